// File: rtl/serial_adder_ctrl_pkg.sv
// Shared constants for the bit-serial add/subtract controller.
package serial_adder_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell shared in time by the serial controller.
module full_adder (
  input  logic ain,
  input  logic bin,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = ain ^ bin ^ cin;
  assign cout = (ain & bin) | (cin & (ain ^ bin));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one full_adder cell, LSB first, WIDTH cycles per op.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] a_sh, a_sh_d;
  logic [WIDTH-1:0] b_sh, b_sh_d;
  logic [WIDTH-1:0] r_sh, r_sh_d;
  logic             c, c_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             busy_d, done_d, cout_d;
  logic [WIDTH-1:0] sum_d;
  logic             fa_sum, fa_cout;
  logic             last_bit;
  logic [WIDTH-1:0] r_shifted;

  full_adder u_fa (
    .ain  (a_sh[0]),
    .bin  (b_sh[0]),
    .cin  (c),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last_bit  = (cnt == CW'(WIDTH - 1));
  assign r_shifted = {fa_sum, r_sh[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last_bit) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and output register next values
  always_comb begin
    a_sh_d = a_sh;
    b_sh_d = b_sh;
    r_sh_d = r_sh;
    c_d    = c;
    cnt_d  = cnt;
    busy_d = busy;
    done_d = 1'b0;
    sum_d  = sum;
    cout_d = cout;
    case (state)
      ST_IDLE: begin
        if (start) begin
          a_sh_d = a;
          b_sh_d = sub ? ~b : b;
          c_d    = sub ? 1'b1 : cin;
          cnt_d  = '0;
          busy_d = 1'b1;
        end
      end
      ST_RUN: begin
        a_sh_d = a_sh >> 1;
        b_sh_d = b_sh >> 1;
        r_sh_d = r_shifted;
        c_d    = fa_cout;
        cnt_d  = cnt + CW'(1);
        if (last_bit) begin
          sum_d  = r_shifted;
          cout_d = fa_cout;
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      r_sh <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      a_sh <= a_sh_d;
      b_sh <= b_sh_d;
      r_sh <= r_sh_d;
      c    <= c_d;
      cnt  <= cnt_d;
      busy <= busy_d;
      done <= done_d;
      sum  <= sum_d;
      cout <= cout_d;
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized self-checking bench for serial_adder_ctrl against an arithmetic reference.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_vec = 0;
  int n_err = 0;
  logic [W:0] prev;  // {cout, sum} the DUT should be holding

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: {cout, sum}; for subtract cout means no borrow.
  function automatic logic [W:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic ci, input logic s);
    if (s) return {(x >= y), W'(x - y)};
    return (W+1)'(x) + (W+1)'(y) + (W+1)'(ci);
  endfunction

  task automatic scramble();
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
    sub = 1'($urandom);
  endtask

  // One operation from edge 0 through edge W+1; optional start pulse during DONE.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic s, input bit poke_done);
    logic [W:0] exp;
    exp   = ref_op(x, y, ci, s);
    a     = x;
    b     = y;
    cin   = ci;
    sub   = s;
    start = 1'b1;
    for (int e = 0; e <= int'(W) + 1; e++) begin
      @(posedge clk);
      #1;
      check("busy", 32'(busy), 32'(e < int'(W)));
      check("done", 32'(done), 32'(e == int'(W)));
      if (e >= int'(W)) check("result", 32'({cout, sum}), 32'(exp));
      else              check("hold", 32'({cout, sum}), 32'(prev));
      if (e == 0) start = 1'b0;
      scramble();
      if (poke_done && e == int'(W)) start = 1'b1;
      if (e == int'(W) + 1) start = 1'b0;
    end
    prev = exp;
  endtask

  initial begin
    logic [W:0] pend;
    int ph;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    prev = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    run_op(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    run_op(8'h10, 8'h01, 1'b1, 1'b1, 1'b0);
    run_op(8'h01, 8'h02, 1'b1, 1'b1, 1'b0);
    run_op(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);

    // start held high with operands changing every cycle
    start = 1'b1;
    scramble();
    pend = '0;
    for (int e = 0; e < 50; e++) begin
      ph = e % (int'(W) + 2);
      if (ph == 0) pend = ref_op(a, b, cin, sub);
      @(posedge clk);
      #1;
      check("cont_busy", 32'(busy), 32'(ph < int'(W)));
      check("cont_done", 32'(done), 32'(ph == int'(W)));
      if (ph >= int'(W)) check("cont_result", 32'({cout, sum}), 32'(pend));
      else               check("cont_hold", 32'({cout, sum}), 32'(prev));
      if (ph == int'(W)) prev = pend;
      scramble();
    end
    start = 1'b0;
    @(posedge clk);
    #1;

    // Reset in the middle of an add
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
    a = 8'h11; b = 8'h22; cin = 1'b0; sub = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    #2;
    rst_n = 1'b1;
    prev = '0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk);
      #1;
      check("abort_nodone", 32'({busy, done}), 32'd0);
    end
    run_op(8'h03, 8'h04, 1'b0, 1'b0, 1'b0);

    // start in DONE is ignored; the following op sees sum held
    run_op(8'hA5, 8'h0F, 1'b0, 1'b1, 1'b1);
    run_op(8'h20, 8'h22, 1'b1, 1'b0, 1'b0);

    // Random operations
    for (int i = 0; i < 30; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
